// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request initiator for the 16-bit word memory port.
// Takes one read or write at a time over a valid/ready handshake, drives the
// memory address/enable/read-write pins and the shared data bus, and returns
// completion on a one-cycle rsp_valid strobe.
// Optional build macro: MEM_BUS_MASTER_READBACK_EN -- every write is followed
// by a readback of the same address; rsp_rdata returns the readback value and
// rsp_error flags a mismatch against the written data.
`timescale 1ns/1ps

module mem_bus_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read_write,
    output logic                  mem_enable,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ADDR,
        READ_DATA
`ifdef MEM_BUS_MASTER_READBACK_EN
        ,
        VERIFY_ADDR,
        VERIFY_DATA
`endif
    } state_t;

    state_t                r_state;
    logic                  r_mem_enable;
    logic                  r_mem_rw;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drive;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
`ifdef MEM_BUS_MASTER_READBACK_EN
    logic                  r_rsp_error;
`endif

    // Ready only while idle and out of reset, so nothing is accepted during reset.
    assign req_ready      = reset && (r_state == IDLE);

    assign mem_enable     = r_mem_enable;
    assign mem_read_write = r_mem_rw;
    assign mem_address    = r_mem_addr;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
`ifdef MEM_BUS_MASTER_READBACK_EN
    assign rsp_error      = r_rsp_error;
`else
    assign rsp_error      = 1'b0;
`endif

    // The bus is driven only in WRITE; r_drive drops on the same edge that
    // returns mem_read_write to 1, so the memory never sees contention.
    assign mem_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

    // Request sequencer: state plus every registered pin and response output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
            r_mem_rw     <= 1'b1;
            r_mem_addr   <= '0;
            r_wdata      <= '0;
            r_drive      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
`ifdef MEM_BUS_MASTER_READBACK_EN
            r_rsp_error  <= 1'b0;
`endif
        end else begin
            // The response strobe lasts exactly one cycle.
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_mem_addr   <= req_addr;
                        r_wdata      <= req_wdata;
                        r_mem_enable <= 1'b1;
                        if (req_write) begin
                            r_state  <= WRITE;
                            r_mem_rw <= 1'b0;
                            r_drive  <= 1'b1;
                        end else begin
                            r_state  <= READ_ADDR;
                            r_mem_rw <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_drive  <= 1'b0;
                    r_mem_rw <= 1'b1;
`ifdef MEM_BUS_MASTER_READBACK_EN
                    // Enable stays high: the readback address phase follows directly.
                    r_state      <= VERIFY_ADDR;
`else
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                    r_rsp_valid  <= 1'b1;
`endif
                end
                READ_ADDR: begin
                    r_state <= READ_DATA;
                end
                READ_DATA: begin
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_rdata  <= mem_data;
`ifdef MEM_BUS_MASTER_READBACK_EN
                    r_rsp_error  <= 1'b0;
`endif
                end
`ifdef MEM_BUS_MASTER_READBACK_EN
                VERIFY_ADDR: begin
                    r_state <= VERIFY_DATA;
                end
                VERIFY_DATA: begin
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_rdata  <= mem_data;
                    r_rsp_error  <= (mem_data != r_wdata);
                end
`endif
                default: begin
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                    r_mem_rw     <= 1'b1;
                    r_drive      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master: behavioural one-cycle-latency memory on the
// shared bus, a weak-style probe driver that marks the bus while the memory
// is disabled, and a scoreboard of expected responses.
`timescale 1ns/1ps

module tb_mem_bus_master;

`ifdef MEM_BUS_MASTER_READBACK_EN
    localparam int LAT_W = 4;
`else
    localparam int LAT_W = 2;
`endif
    localparam int LAT_R = 3;
    localparam logic [15:0] PROBE = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    wire         req_ready;
    wire         rsp_valid;
    wire  [15:0] rsp_rdata;
    wire         rsp_error;
    wire  [15:0] mem_address;
    wire         mem_read_write;
    wire         mem_enable;
    wire  [15:0] mem_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_enable(mem_enable), .mem_data(mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [15:0] mem [0:65535];
    logic [15:0] mem_q = 16'h0000;
    logic        corrupt_on = 1'b0;

    function automatic logic [15:0] stored_val(input logic [15:0] a, input logic [15:0] d);
        return (corrupt_on && a == 16'h0020) ? (d ^ 16'h0F0F) : d;
    endfunction

    always @(posedge clk) begin
        if (mem_enable === 1'b1) begin
            if (mem_read_write === 1'b0) mem[mem_address] <= stored_val(mem_address, mem_data);
            else                         mem_q <= mem[mem_address];
        end
    end
    assign mem_data = (mem_enable === 1'b1 && mem_read_write === 1'b1) ? mem_q : 16'hzzzz;
    assign mem_data = (mem_enable === 1'b0) ? PROBE : 16'hzzzz;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [15:0] rdata;
        logic        err;
        int          id;
    } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] last_rdata = 16'h0000;
    int          next_id = 0;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d got rsp_valid=1 rdata=%h want no response", cyc, rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || rsp_rdata !== mon_e.rdata || rsp_error !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp_%0d got cyc=%0d rdata=%h err=%b want cyc=%0d rdata=%h err=%b",
                             mon_e.id, cyc, rsp_rdata, rsp_error, mon_e.cyc, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    // Presents one request; returns at the negedge of cycle 1.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit track);
        exp_t        e;
        int          n;
        logic [15:0] sv;
        n = 0;
        while (req_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_ready got req_ready=%b want 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        e.id = next_id;
        next_id++;
        e.err = 1'b0;
        if (wr) begin
            sv = stored_val(a, d);
            model_mem[a] = sv;
            e.cyc = cyc + LAT_W;
`ifdef MEM_BUS_MASTER_READBACK_EN
            e.rdata = sv;
            e.err   = (sv != d);
`else
            e.rdata = last_rdata;
`endif
        end else begin
            e.cyc   = cyc + LAT_R;
            e.rdata = model_mem.exists(a) ? model_mem[a] : 16'h0000;
        end
        if (track) begin
            last_rdata = e.rdata;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending responses want 0", sb.size());
            sb.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 16'h0010;
        repeat (3) begin
            @(negedge clk);
            checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %b want 0", mem_enable); end
            checks++; if (mem_read_write !== 1'b1) begin errors++; $display("FAIL rst_rw got %b want 1", mem_read_write); end
            checks++; if (mem_data !== PROBE) begin errors++; $display("FAIL rst_bus_released got %h want %h", mem_data, PROBE); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
            checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", mem_address); end
        end
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL rst_no_accept got enable=%b want 0", mem_enable); end
        checks++; if (rsp_rdata !== 16'h0000 || rsp_error !== 1'b0) begin errors++; $display("FAIL rst_rsp_regs got rdata=%h err=%b want 0000/0", rsp_rdata, rsp_error); end
    endtask

    task automatic test_write();
        issue(1'b1, 16'h0010, 16'hBEEF, 1'b1);
        // cycle 1: WRITE
        checks++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b0) begin errors++; $display("FAIL wr_pins got en=%b rw=%b want 1/0", mem_enable, mem_read_write); end
        checks++; if (mem_address !== 16'h0010) begin errors++; $display("FAIL wr_addr got %h want 0010", mem_address); end
        checks++; if (mem_data !== 16'hBEEF) begin errors++; $display("FAIL wr_data got %h want BEEF", mem_data); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_busy got req_ready=%b want 0", req_ready); end
        @(negedge clk);
        // cycle 2: IDLE with response, or readback address phase
        checks++; if (mem_enable !== (LAT_W == 4)) begin errors++; $display("FAIL wr_cycle2_enable got %b want %b", mem_enable, (LAT_W == 4)); end
        checks++; if (mem_read_write !== 1'b1) begin errors++; $display("FAIL wr_cycle2_rw got %b want 1", mem_read_write); end
        wait_drain();
    endtask

    task automatic test_read();
        issue(1'b0, 16'h0010, 16'h0000, 1'b1);
        checks++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1) begin errors++; $display("FAIL rd_c1_pins got en=%b rw=%b want 1/1", mem_enable, mem_read_write); end
        checks++; if (mem_address !== 16'h0010) begin errors++; $display("FAIL rd_addr got %h want 0010", mem_address); end
        @(negedge clk);
        checks++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1) begin errors++; $display("FAIL rd_c2_pins got en=%b rw=%b want 1/1", mem_enable, mem_read_write); end
        checks++; if (mem_data !== 16'hBEEF) begin errors++; $display("FAIL rd_c2_bus got %h want BEEF", mem_data); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 16'h0010, 16'h0000, 1'b1);
        repeat (LAT_R - 1) @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got ready=%b rsp_valid=%b want 1/1", req_ready, rsp_valid); end
        issue(1'b1, 16'hFFFF, 16'h1234, 1'b1);
        checks++; if (mem_address !== 16'hFFFF || mem_data !== 16'h1234) begin errors++; $display("FAIL b2b_wr_pins got addr=%h data=%h want FFFF/1234", mem_address, mem_data); end
        repeat (LAT_W - 1) @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got ready=%b rsp_valid=%b want 1/1", req_ready, rsp_valid); end
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b1);
        wait_drain();
    endtask

`ifdef MEM_BUS_MASTER_READBACK_EN
    task automatic test_readback_corrupt();
        corrupt_on = 1'b1;
        issue(1'b1, 16'h0020, 16'h00FF, 1'b1);
        @(negedge clk);
        checks++; if (mem_enable !== 1'b1 || mem_read_write !== 1'b1 || mem_address !== 16'h0020) begin errors++; $display("FAIL rb_verify_pins got en=%b rw=%b addr=%h want 1/1/0020", mem_enable, mem_read_write, mem_address); end
        wait_drain();
        corrupt_on = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 8; i++) issue(1'b1, 16'h0100 + 16'(i), 16'($urandom_range(1, 65535)), 1'b1);
        for (int i = 0; i < 24; i++) begin
            a = 16'h0100 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) issue(1'b1, a, 16'($urandom_range(1, 65535)), 1'b1);
            else                           issue(1'b0, a, 16'h0000, 1'b1);
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        issue(1'b0, 16'h0010, 16'h0000, 1'b1);
        wait_drain();
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        // in READ_DATA now; abort
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mem_enable !== 1'b0 || mem_read_write !== 1'b1) begin errors++; $display("FAIL abort_pins got en=%b rw=%b want 0/1", mem_enable, mem_read_write); end
        checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL abort_addr got %h want 0000", mem_address); end
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || rsp_error !== 1'b0) begin errors++; $display("FAIL abort_rsp got v=%b rdata=%h err=%b want 0/0000/0", rsp_valid, rsp_rdata, rsp_error); end
        checks++; if (mem_data !== PROBE) begin errors++; $display("FAIL abort_bus got %h want %h", mem_data, PROBE); end
        reset = 1'b1;
        last_rdata = 16'h0000;
        repeat (4) @(negedge clk);
        issue(1'b0, 16'h0010, 16'h0000, 1'b1);
        wait_drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
`ifdef MEM_BUS_MASTER_READBACK_EN
        test_readback_corrupt();
`endif
        test_random();
        test_reset_abort();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
